// File: rtl/bnn_pkg.sv
// -----------------------------------------------------------------------------
// bnn_pkg
// Shared definitions for the BNN PE-array top and its host-side stream
// sequencer: the sequencer FSM state encoding and the derived run-length
// constants (stream words N, popped psums P) as functions of the parameters.
// -----------------------------------------------------------------------------
package bnn_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_PREFETCH = 3'd1,
      ST_STREAM   = 3'd2,
      ST_POP      = 3'd3,
      ST_FLUSH    = 3'd4
   } seq_state_e;

   // PREFETCH fills the read-data and output-register stages; FLUSH emits the
   // last result write and then the done cycle.
   localparam int PREFETCH_CYCLES = 2;
   localparam int FLUSH_CYCLES    = 2;

   // Words streamed per run: every group is O_CH weights then
   // OUT_ROW_LENGTH activations.
   function automatic int seq_stream_words(input int o_ch, input int i_ch,
                                           input int out_row_length);
      return i_ch * (o_ch + out_row_length);
   endfunction

   // Psums popped per run.
   function automatic int seq_pop_count(input int o_ch, input int out_row_length);
      return o_ch * out_row_length;
   endfunction

   // Width of a counter that must reach max(n, p) - 1.
   function automatic int seq_cnt_width(input int n, input int p);
      int m;
      m = (n > p) ? n : p;
      return (m > 2) ? $clog2(m) : 1;
   endfunction

endpackage

// File: rtl/bnn_stream_sequencer_if.sv
// -----------------------------------------------------------------------------
// bnn_stream_sequencer_if
// Stream port between the sequencer (master) and the BNN PE array (slave).
//   data_out        : stream word (weight or activation)
//   load_weight_out : data_out carries a weight
//   in_valid_out    : data_out carries an activation
//   pop_out         : array must present one psum on sum_in this cycle
//   sum_in          : psum returned by the array, same cycle as pop_out
// -----------------------------------------------------------------------------
interface bnn_stream_sequencer_if #(
   parameter int DATA_W = 9,
   parameter int WIDTH  = 14
);
   logic [DATA_W-1:0] data_out;
   logic              load_weight_out;
   logic              in_valid_out;
   logic              pop_out;
   logic [WIDTH-1:0]  sum_in;

   modport master (
      output data_out, load_weight_out, in_valid_out, pop_out,
      input  sum_in
   );

   modport slave (
      input  data_out, load_weight_out, in_valid_out, pop_out,
      output sum_in
   );
endinterface

// File: rtl/bnn_seq_addr_gen.sv
// -----------------------------------------------------------------------------
// bnn_seq_addr_gen
// Data-buffer read address generator for the stream sequencer. Holds the
// read-address counter and the offset within the current input-channel group,
// and classifies the word being read as weight or activation.
// Ports:
//   clk_in, rst_in : clock, asynchronous active-low reset
//   launch         : run accepted; first read (address 0) follows next cycle
//   rd_en, rd_addr : read strobe/address, addresses 0..N-1 on consecutive cycles
//   is_weight      : word at rd_addr is a weight (group offset < O_CH)
// -----------------------------------------------------------------------------
module bnn_seq_addr_gen
   import bnn_pkg::*;
#(
   parameter int O_CH           = 64,
   parameter int I_CH           = 3,
   parameter int OUT_ROW_LENGTH = 4,
   parameter int RD_AW          = 8
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             launch,
   output logic             rd_en,
   output logic [RD_AW-1:0] rd_addr,
   output logic             is_weight
);

   localparam int N     = seq_stream_words(O_CH, I_CH, OUT_ROW_LENGTH);
   localparam int G     = O_CH + OUT_ROW_LENGTH;
   localparam int OFF_W = (G > 2) ? $clog2(G) : 1;

   localparam logic [RD_AW-1:0] RD_LAST  = RD_AW'(N - 1);
   localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(G - 1);
   localparam logic [OFF_W-1:0] OFF_WGT  = OFF_W'(O_CH);

   logic             en_q;
   logic [RD_AW-1:0] addr_q;
   logic [OFF_W-1:0] off_q;

   // Address counter stops at N-1; the group offset wraps at each group edge.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         en_q   <= 1'b0;
         addr_q <= '0;
         off_q  <= '0;
      end else if (launch) begin
         en_q   <= 1'b1;
         addr_q <= '0;
         off_q  <= '0;
      end else if (en_q) begin
         if (addr_q == RD_LAST) begin
            en_q <= 1'b0;
         end else begin
            addr_q <= addr_q + 1'b1;
            off_q  <= (off_q == OFF_LAST) ? '0 : off_q + 1'b1;
         end
      end
   end

   assign rd_en     = en_q;
   assign rd_addr   = en_q ? addr_q : '0;
   assign is_weight = (off_q < OFF_WGT);

endmodule

// File: rtl/bnn_stream_sequencer.sv
// -----------------------------------------------------------------------------
// bnn_stream_sequencer
// Host-side driver for the BNN PE array. Reads the packed weight/activation
// image from the data buffer, replays it on the stream port as a gap-free
// stream, then pops every psum and writes it to the result buffer.
// Ports:
//   clk_in, rst_in       : clock, asynchronous active-low reset
//   start                : run request, sampled only when idle
//   busy, done           : run in progress / one-cycle completion pulse
//   rd_en, rd_addr       : data-buffer read; rd_data valid one cycle later
//   strm (master)        : stream port to the array (data/flags/pop/sum)
//   res_wr_en/addr/data  : result-buffer write port
//   checksum             : only with SEQ_CHECKSUM_EN defined; unsigned sum of
//                          all result words written in the current run
// Optional feature macro: SEQ_CHECKSUM_EN
// -----------------------------------------------------------------------------
module bnn_stream_sequencer
   import bnn_pkg::*;
#(
   parameter int O_CH           = 64,
   parameter int I_CH           = 3,
   parameter int OUT_ROW_LENGTH = 4,
   parameter int DATA_W         = 9,
   parameter int WIDTH          = 14,
   parameter int RD_AW          = 8,
   parameter int WR_AW          = 8
) (
   input  logic                   clk_in,
   input  logic                   rst_in,
   input  logic                   start,
   output logic                   busy,
   output logic                   done,
   output logic                   rd_en,
   output logic [RD_AW-1:0]       rd_addr,
   input  logic [DATA_W-1:0]      rd_data,
   bnn_stream_sequencer_if.master strm,
   output logic                   res_wr_en,
   output logic [WR_AW-1:0]       res_addr,
   output logic [WIDTH-1:0]       res_data
`ifdef SEQ_CHECKSUM_EN
   ,
   output logic [WIDTH+WR_AW-1:0] checksum
`endif
);

   localparam int N     = seq_stream_words(O_CH, I_CH, OUT_ROW_LENGTH);
   localparam int P     = seq_pop_count(O_CH, OUT_ROW_LENGTH);
   localparam int CNT_W = seq_cnt_width(N, P);

   localparam logic [CNT_W-1:0] PRE_LAST   = CNT_W'(PREFETCH_CYCLES - 1);
   localparam logic [CNT_W-1:0] N_LAST     = CNT_W'(N - 1);
   localparam logic [CNT_W-1:0] P_LAST     = CNT_W'(P - 1);
   localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_CYCLES - 1);
   localparam logic [WR_AW-1:0] WR_LAST    = WR_AW'(P - 1);

   seq_state_e       state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             launch;
   logic             pop;

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // cnt counts cycles spent in the current state.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt + 1'b1;
      launch    = 1'b0;
      case (state)
         ST_IDLE: begin
            cnt_nxt = '0;
            if (start) begin
               launch    = 1'b1;
               state_nxt = ST_PREFETCH;
            end
         end
         ST_PREFETCH: begin
            if (cnt == PRE_LAST) begin
               state_nxt = ST_STREAM;
               cnt_nxt   = '0;
            end
         end
         ST_STREAM: begin
            if (cnt == N_LAST) begin
               state_nxt = ST_POP;
               cnt_nxt   = '0;
            end
         end
         ST_POP: begin
            if (cnt == P_LAST) begin
               state_nxt = ST_FLUSH;
               cnt_nxt   = '0;
            end
         end
         ST_FLUSH: begin
            if (cnt == FLUSH_LAST) begin
               state_nxt = ST_IDLE;
               cnt_nxt   = '0;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   assign busy = (state != ST_IDLE);
   assign done = (state == ST_FLUSH) && (cnt == FLUSH_LAST);
   assign pop  = (state == ST_POP);

   // ---- stage p0: read address issue ----
   logic is_weight_p0;

   bnn_seq_addr_gen #(
      .O_CH           (O_CH),
      .I_CH           (I_CH),
      .OUT_ROW_LENGTH (OUT_ROW_LENGTH),
      .RD_AW          (RD_AW)
   ) u_addr_gen (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .launch    (launch),
      .rd_en     (rd_en),
      .rd_addr   (rd_addr),
      .is_weight (is_weight_p0)
   );

   // ---- stage p1: read data returning from the buffer ----
   logic vld_p1, wgt_p1;

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         vld_p1 <= 1'b0;
         wgt_p1 <= 1'b0;
      end else begin
         vld_p1 <= rd_en;
         wgt_p1 <= is_weight_p0;
      end
   end

   // ---- stage p2: registered stream outputs ----
   logic [DATA_W-1:0] data_p2;
   logic              lw_p2, iv_p2;

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         data_p2 <= '0;
         lw_p2   <= 1'b0;
         iv_p2   <= 1'b0;
      end else begin
         data_p2 <= vld_p1 ? rd_data : '0;
         lw_p2   <= vld_p1 &  wgt_p1;
         iv_p2   <= vld_p1 & ~wgt_p1;
      end
   end

   assign strm.data_out        = data_p2;
   assign strm.load_weight_out = lw_p2;
   assign strm.in_valid_out    = iv_p2;
   assign strm.pop_out         = pop;

   // ---- pop index: result address of the psum presented this cycle ----
   logic [WR_AW-1:0] wr_idx;

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         wr_idx <= '0;
      end else if (launch) begin
         wr_idx <= '0;
      end else if (pop && (wr_idx != WR_LAST)) begin
         wr_idx <= wr_idx + 1'b1;
      end
   end

   // ---- stage w1: registered result write ----
   logic             vld_w1;
   logic [WR_AW-1:0] addr_w1;
   logic [WIDTH-1:0] data_w1;

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         vld_w1  <= 1'b0;
         addr_w1 <= '0;
         data_w1 <= '0;
      end else begin
         vld_w1  <= pop;
         addr_w1 <= pop ? wr_idx : '0;
         data_w1 <= pop ? strm.sum_in : '0;
      end
   end

   assign res_wr_en = vld_w1;
   assign res_addr  = addr_w1;
   assign res_data  = data_w1;

`ifdef SEQ_CHECKSUM_EN
   // Holds its value after the last write until the next accepted start.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         checksum <= '0;
      end else if (launch) begin
         checksum <= '0;
      end else if (vld_w1) begin
         checksum <= checksum + (WIDTH+WR_AW)'(data_w1);
      end
   end
`endif

endmodule

// File: tb/tb_bnn_stream_sequencer.sv
// -----------------------------------------------------------------------------
// tb_bnn_stream_sequencer
// Two sequencers side by side: A with default parameters, B with O_CH=2,
// I_CH=1, OUT_ROW_LENGTH=2. A timeline model (outputs as a function of the
// cycle offset from the accepted start) is compared against both every cycle,
// and literal expectations pin the model for the first run.
// -----------------------------------------------------------------------------
module tb_bnn_stream_sequencer;

   localparam int NA = 204, PA = 256, GA = 68, OCA = 64;
   localparam int NB = 4,   PB = 4,   GB = 4,  OCB = 2;

   logic clk = 1'b0;
   logic rst_in = 1'b1;
   logic start = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   int ta = -1, tb = -1;
   int t_go = 0;
   int wcnt_a = 0;

   logic [8:0]  mem_a [0:255];
   logic [8:0]  mem_b [0:255];
   logic [13:0] ps_a  [0:255];
   logic [13:0] ps_b  [0:255];

   // DUT A signals
   logic        busy_a, done_a, rd_en_a, res_wr_en_a;
   logic [7:0]  rd_addr_a, res_addr_a;
   logic [8:0]  rd_data_a = '0;
   logic [13:0] res_data_a;
   // DUT B signals
   logic        busy_b, done_b, rd_en_b, res_wr_en_b;
   logic [7:0]  rd_addr_b, res_addr_b;
   logic [8:0]  rd_data_b = '0;
   logic [13:0] res_data_b;
`ifdef SEQ_CHECKSUM_EN
   logic [21:0] checksum_a, checksum_b;
`endif

   bnn_stream_sequencer_if #(.DATA_W(9), .WIDTH(14)) if_a ();
   bnn_stream_sequencer_if #(.DATA_W(9), .WIDTH(14)) if_b ();

   bnn_stream_sequencer dut_a (
      .clk_in(clk), .rst_in(rst_in), .start(start), .busy(busy_a), .done(done_a),
      .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a), .strm(if_a),
      .res_wr_en(res_wr_en_a), .res_addr(res_addr_a), .res_data(res_data_a)
`ifdef SEQ_CHECKSUM_EN
      , .checksum(checksum_a)
`endif
   );

   bnn_stream_sequencer #(.O_CH(2), .I_CH(1), .OUT_ROW_LENGTH(2)) dut_b (
      .clk_in(clk), .rst_in(rst_in), .start(start), .busy(busy_b), .done(done_b),
      .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b), .strm(if_b),
      .res_wr_en(res_wr_en_b), .res_addr(res_addr_b), .res_data(res_data_b)
`ifdef SEQ_CHECKSUM_EN
      , .checksum(checksum_b)
`endif
   );

   // Synchronous data buffers and array psum sources
   int pc_a = 0, pc_b = 0;
   always @(posedge clk) begin
      if (rd_en_a) rd_data_a <= mem_a[rd_addr_a];
      if (rd_en_b) rd_data_b <= mem_b[rd_addr_b];
      if (!busy_a) pc_a <= 0; else if (if_a.pop_out) pc_a <= pc_a + 1;
      if (!busy_b) pc_b <= 0; else if (if_b.pop_out) pc_b <= pc_b + 1;
   end
   assign if_a.sum_in = if_a.pop_out ? ps_a[pc_a[7:0]] : '0;
   assign if_b.sum_in = if_b.pop_out ? ps_b[pc_b[7:0]] : '0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic bit mbusy(input int t, input int n, input int p, input int c);
      return (t >= 0) && (c >= t + 1) && (c <= t + n + p + 4);
   endfunction

   // Model: run accepted when start is high in a cycle the block is not busy.
   always @(posedge clk) begin
      if (!rst_in) begin
         ta = -1;
         tb = -1;
      end else begin
         if (start && !mbusy(ta, NA, PA, cyc)) ta = cyc;
         if (start && !mbusy(tb, NB, PB, cyc)) tb = cyc;
      end
      cyc++;
   end

   // Expected outputs at cycle offset rel from the accepted start.
   task automatic chk_run(input string id, input int rel, input int n, input int p,
                          input int g, input int och, input logic [8:0] ew, input logic [13:0] ep,
                          input logic busy, input logic done, input logic rd_en,
                          input logic [7:0] rd_addr, input logic [8:0] d, input logic lw,
                          input logic iv, input logic pop, input logic wr,
                          input logic [7:0] ra, input logic [13:0] rdat);
      bit in_rd, in_st, in_wr, is_w;
      in_rd = (rel >= 1) && (rel <= n);
      in_st = (rel >= 3) && (rel <= n + 2);
      in_wr = (rel >= n + 4) && (rel <= n + 3 + p);
      is_w  = in_st && (((rel - 3) % g) < och);
      chk({id, ".busy"},    32'(busy),    32'((rel >= 1) && (rel <= n + p + 4)));
      chk({id, ".done"},    32'(done),    32'(rel == n + p + 4));
      chk({id, ".rd_en"},   32'(rd_en),   32'(in_rd));
      chk({id, ".rd_addr"}, 32'(rd_addr), in_rd ? 32'(rel - 1) : 32'd0);
      chk({id, ".data"},    32'(d),       in_st ? 32'(ew) : 32'd0);
      chk({id, ".lw"},      32'(lw),      32'(is_w));
      chk({id, ".iv"},      32'(iv),      32'(in_st && !is_w));
      chk({id, ".pop"},     32'(pop),     32'((rel >= n + 3) && (rel <= n + 2 + p)));
      chk({id, ".wr_en"},   32'(wr),      32'(in_wr));
      chk({id, ".wr_addr"}, 32'(ra),      in_wr ? 32'(rel - n - 4) : 32'd0);
      chk({id, ".wr_data"}, 32'(rdat),    in_wr ? 32'(ep) : 32'd0);
   endtask

   always @(negedge clk) begin : cmp
      int ra, rb, k, j;
      logic [8:0]  ew;
      logic [13:0] ep;
      ra = (rst_in && ta >= 0) ? cyc - ta : -1000;
      rb = (rst_in && tb >= 0) ? cyc - tb : -1000;
      k = ra - 3; j = ra - NA - 4;
      ew = (k >= 0 && k < NA) ? mem_a[k] : '0;
      ep = (j >= 0 && j < PA) ? ps_a[j] : '0;
      chk_run("a", ra, NA, PA, GA, OCA, ew, ep, busy_a, done_a, rd_en_a, rd_addr_a,
              if_a.data_out, if_a.load_weight_out, if_a.in_valid_out, if_a.pop_out,
              res_wr_en_a, res_addr_a, res_data_a);
      k = rb - 3; j = rb - NB - 4;
      ew = (k >= 0 && k < NB) ? mem_b[k] : '0;
      ep = (j >= 0 && j < PB) ? ps_b[j] : '0;
      chk_run("b", rb, NB, PB, GB, OCB, ew, ep, busy_b, done_b, rd_en_b, rd_addr_b,
              if_b.data_out, if_b.load_weight_out, if_b.in_valid_out, if_b.pop_out,
              res_wr_en_b, res_addr_b, res_data_b);
   end

   // Per-run totals for A, checked at each done
   always @(negedge clk) begin : mon
      int s;
      if (!rst_in) begin
         wcnt_a = 0;
      end else begin
         if (res_wr_en_a) wcnt_a++;
         if (done_a) begin
            chk("a.done_at", 32'(cyc - t_go), 32'd464);
            chk("a.writes", 32'(wcnt_a), 32'd256);
            wcnt_a = 0;
`ifdef SEQ_CHECKSUM_EN
            s = 0;
            for (int i = 0; i < PA; i++) s += int'(ps_a[i]);
            chk("a.checksum", 32'(checksum_a), 32'(s));
`endif
         end
`ifdef SEQ_CHECKSUM_EN
         if (done_b) begin
            s = 0;
            for (int i = 0; i < PB; i++) s += int'(ps_b[i]);
            chk("b.checksum", 32'(checksum_b), 32'(s));
         end
`endif
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_cyc(input int c);
      while (cyc < c) @(negedge clk);
      #1;
   endtask

   task automatic wait_done_a(input int limit);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < limit && !seen; i++) begin
         @(negedge clk);
         #1;
         if (done_a) seen = 1'b1;
      end
      if (!seen) begin
         n_chk++;
         n_fail++;
         $display("FAIL a.done_timeout: no done within %0d cycles (cycle %0d)", limit, cyc);
      end
   endtask

   task automatic randomize_data();
      for (int i = 0; i < 256; i++) begin
         mem_a[i] = 9'($urandom_range(0, 511));
         mem_b[i] = 9'($urandom_range(0, 511));
         ps_a[i]  = 14'($urandom);
         ps_b[i]  = 14'($urandom);
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem_a[i] = 9'(i % 512);
         mem_b[i] = 9'(i % 512);
         ps_a[i]  = 14'(32'h100 + i);
         ps_b[i]  = 14'(32'h100 + i);
      end
      #1 rst_in = 1'b0;
      tick(3);
      #1;
      chk("rst.busy", 32'(busy_a), 32'd0);
      chk("rst.rd_en", 32'(rd_en_a), 32'd0);
      chk("rst.data", 32'(if_a.data_out), 32'd0);
      chk("rst.wr_en", 32'(res_wr_en_a), 32'd0);
      @(negedge clk);
      rst_in = 1'b1;
      tick(2);

      // Run 1: fixed image, literal pins on both instances
      t_go = cyc;
      pulse_start();
      wait_cyc(t_go + 3);
      chk("a.k0_data", 32'(if_a.data_out), 32'd0);
      chk("a.k0_lw", 32'(if_a.load_weight_out), 32'd1);
      wait_cyc(t_go + 5);
      chk("b.k2_data", 32'(if_b.data_out), 32'd2);
      chk("b.k2_iv", 32'(if_b.in_valid_out), 32'd1);
      wait_cyc(t_go + 12);
      chk("b.done_at", 32'(done_b), 32'd1);
      wait_cyc(t_go + 67);
      chk("a.k64_data", 32'(if_a.data_out), 32'd64);
      chk("a.k64_iv", 32'(if_a.in_valid_out), 32'd1);
      wait_cyc(t_go + 202);
      chk("a.k199_lw", 32'(if_a.load_weight_out), 32'd1);
      wait_cyc(t_go + 206);
      chk("a.k203_data", 32'(if_a.data_out), 32'd203);
      chk("a.k203_pop", 32'(if_a.pop_out), 32'd0);
      wait_cyc(t_go + 207);
      chk("a.pop0", 32'(if_a.pop_out), 32'd1);
      wait_cyc(t_go + 208);
      chk("a.w0_data", 32'(res_data_a), 32'h100);
      wait_cyc(t_go + 463);
      chk("a.w255_addr", 32'(res_addr_a), 32'd255);
      chk("a.w255_data", 32'(res_data_a), 32'h1ff);
      wait_cyc(t_go + 464);
      chk("a.done_lit", 32'(done_a), 32'd1);
`ifdef SEQ_CHECKSUM_EN
      chk("a.checksum_lit", 32'(checksum_a), 32'd98176);
`endif
      tick(3);

      // Run 2: random image, extra start mid-run must be ignored by A
      randomize_data();
      t_go = cyc;
      pulse_start();
      wait_cyc(t_go + 50);
      pulse_start();
      wait_done_a(500);
      tick(2);

      // Run 3: reset abort during STREAM
      randomize_data();
      t_go = cyc;
      pulse_start();
      wait_cyc(t_go + 100);
      @(posedge clk);
      #2 rst_in = 1'b0;
      #1;
      chk("abort.busy", 32'(busy_a), 32'd0);
      chk("abort.rd_en", 32'(rd_en_a), 32'd0);
      chk("abort.rd_addr", 32'(rd_addr_a), 32'd0);
      chk("abort.data", 32'(if_a.data_out), 32'd0);
      chk("abort.lw", 32'(if_a.load_weight_out), 32'd0);
      chk("abort.iv", 32'(if_a.in_valid_out), 32'd0);
      tick(4);
      rst_in = 1'b1;
      tick(10);
      #1;
      chk("abort.idle", 32'(busy_a), 32'd0);

      // Run 4 and back-to-back run 5 with identical data
      randomize_data();
      t_go = cyc;
      pulse_start();
      wait_done_a(500);
      @(negedge clk);
      t_go = cyc;
      pulse_start();
      wait_done_a(500);
      tick(3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
